// File: rtl/instr_fetch_issue_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and memory (slave).
interface instr_fetch_issue_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               imemReq;
  logic [ADDR_W-1:0]  imemAddr;
  logic [INSTR_W-1:0] imemRdata;
  logic               imemAck;

  modport master (output imemReq, imemAddr, input  imemRdata, imemAck);
  modport slave  (input  imemReq, imemAddr, output imemRdata, imemAck);
endinterface

// File: rtl/instr_fetch_issue.sv
// Fetch/issue front end: fetches 16-bit instructions, presents opCode to control, computes next PC.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_issue #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rstN,
  instr_fetch_issue_if.master imem,
  output logic [INSTR_W-1:0]  instr,
  output logic [3:0]          opCode,
  output logic                instrValid,
  input  logic                issueReady,
  input  logic                jump,
  input  logic                branch,
  input  logic                halt,
  input  logic                aluZero,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic                fetchErr
);

  localparam logic [1:0] ST_RST    = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] brOff;
  logic [ADDR_W-1:0] seqPc;
  logic              fetchTimeout;

  // Request/valid are pure state decodes so reset drops them immediately
  assign imem.imemReq  = (state == ST_FETCH);
  assign imem.imemAddr = pc;
  assign instrValid    = (state == ST_ISSUE);
  assign halted        = (state == ST_HALTED);
  assign opCode        = instr[INSTR_W-1 -: 4];

  assign brOff = {{(ADDR_W-4){instr[3]}}, instr[3:0]};
  assign seqPc = pc + ADDR_W'(1);

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] waitCnt;

  assign fetchTimeout = (state == ST_FETCH) && !imem.imemAck && (waitCnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      waitCnt  <= '0;
      fetchErr <= 1'b0;
    end else begin
      if (state != ST_FETCH || imem.imemAck) waitCnt <= '0;
      else                                   waitCnt <= waitCnt + CNT_W'(1);
      if (fetchTimeout) fetchErr <= 1'b1;
    end
  end
`else
  assign fetchTimeout = 1'b0;
  assign fetchErr     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= ST_RST;
      pc    <= '0;
      instr <= '0;
    end else begin
      case (state)
        ST_RST: state <= ST_FETCH;
        ST_FETCH: begin
          if (imem.imemAck) begin
            instr <= imem.imemRdata;
            state <= ST_ISSUE;
          end else if (fetchTimeout) begin
            state <= ST_HALTED;
          end
        end
        ST_ISSUE: begin
          if (issueReady) begin
            if (halt) begin
              state <= ST_HALTED;
            end else begin
              state <= ST_FETCH;
              if (jump)                  pc <= instr[ADDR_W-1:0];
              else if (branch && aluZero) pc <= seqPc + brOff;
              else                        pc <= seqPc;
            end
          end
        end
        default: state <= ST_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Directed bench for instr_fetch_issue: sequential, branch, jump, halt, back-pressure, wrap, reset, timeout.
module tb_instr_fetch_issue;
  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic [15:0] instr;
  logic [3:0]  opCode;
  logic        instrValid;
  logic        issueReady = 1'b0;
  logic        jump = 1'b0, branch = 1'b0, halt = 1'b0, aluZero = 1'b0;
  logic [7:0]  pc;
  logic        halted, fetchErr;
  int          nAssert = 0;
  int          nFail = 0;

  instr_fetch_issue_if #(.ADDR_W(8), .INSTR_W(16)) imem ();

  instr_fetch_issue #(.ADDR_W(8), .INSTR_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .rstN(rstN), .imem(imem), .instr(instr), .opCode(opCode),
    .instrValid(instrValid), .issueReady(issueReady), .jump(jump), .branch(branch),
    .halt(halt), .aluZero(aluZero), .pc(pc), .halted(halted), .fetchErr(fetchErr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered in FETCH: hold request for one cycle, ack in the second, then check ISSUE.
  task automatic fetch(input logic [7:0] addr, input logic [15:0] data);
    check("fetchReq", imem.imemReq, 1'b1);
    check("fetchAddr", imem.imemAddr, addr);
    check("fetchNoValid", instrValid, 1'b0);
    tick();
    check("fetchHoldReq", imem.imemReq, 1'b1);
    check("fetchHoldAddr", imem.imemAddr, addr);
    imem.imemAck = 1'b1;
    imem.imemRdata = data;
    tick();
    imem.imemAck = 1'b0;
    imem.imemRdata = 16'hDEAD;
    check("issueValid", instrValid, 1'b1);
    check("issueNoReq", imem.imemReq, 1'b0);
    check("issueInstr", instr, data);
    check("issueOpCode", opCode, data[15:12]);
  endtask

  task automatic issue(input logic j, input logic b, input logic z, input logic h);
    issueReady = 1'b1; jump = j; branch = b; aluZero = z; halt = h;
    tick();
    issueReady = 1'b0; jump = 1'b0; branch = 1'b0; aluZero = 1'b0; halt = 1'b0;
  endtask

  initial begin
    imem.imemAck = 1'b0;
    imem.imemRdata = '0;
    #2 rstN = 1'b0;
    #18;
    check("rstPc", pc, 8'h00);
    check("rstInstr", instr, 16'h0000);
    check("rstOpCode", opCode, 4'h0);
    check("rstReq", imem.imemReq, 1'b0);
    check("rstValid", instrValid, 1'b0);
    check("rstHalted", halted, 1'b0);
    check("rstErr", fetchErr, 1'b0);
    #2 rstN = 1'b1;
    tick();

    // Sequential fetch/issue
    fetch(8'h00, 16'h0123);
    issue(0, 0, 0, 0);
    check("seqPc1", pc, 8'h01);
    fetch(8'h01, 16'h6456);
    issue(0, 0, 0, 0);
    check("seqPc2", pc, 8'h02);

    // Jump to 0x10, then branch taken (-2) and not taken
    fetch(8'h02, 16'h8010);
    issue(1, 0, 0, 0);
    check("jumpPc", pc, 8'h10);
    fetch(8'h10, 16'h200E);
    issue(0, 1, 1, 0);
    check("brTakenPc", pc, 8'h0F);
    fetch(8'h0F, 16'h8010);
    issue(1, 0, 0, 0);
    fetch(8'h10, 16'h200E);
    issue(0, 1, 0, 0);
    check("brNotTakenPc", pc, 8'h11);

    // Back-pressure with stray ack and ignored jump; instr must hold
    fetch(8'h11, 16'h80FF);
    jump = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem.imemAck = (i == 2);
      imem.imemRdata = 16'h1234;
      tick();
      check("bpValid", instrValid, 1'b1);
      check("bpOpCode", opCode, 4'h8);
      check("bpInstr", instr, 16'h80FF);
      check("bpPc", pc, 8'h11);
      check("bpNoReq", imem.imemReq, 1'b0);
    end
    imem.imemAck = 1'b0;
    jump = 1'b0;
    issue(1, 0, 0, 0);
    check("jumpFFPc", pc, 8'hFF);

    // Wrap and negative branch from 0
    fetch(8'hFF, 16'h0000);
    issue(0, 0, 0, 0);
    check("wrapPc", pc, 8'h00);
    fetch(8'h00, 16'h200C);
    issue(0, 1, 1, 0);
    check("brNegPc", pc, 8'hFD);

    // Jump and halt together: halt wins
    fetch(8'hFD, 16'h803C);
    issue(1, 0, 0, 1);
    check("haltFlag", halted, 1'b1);
    check("haltPc", pc, 8'hFD);
    check("haltReq", imem.imemReq, 1'b0);
    check("haltValid", instrValid, 1'b0);
    imem.imemAck = 1'b1;
    imem.imemRdata = 16'hBEEF;
    issueReady = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    imem.imemAck = 1'b0;
    issueReady = 1'b0;
    check("haltStayFlag", halted, 1'b1);
    check("haltStayReq", imem.imemReq, 1'b0);
    check("haltStayPc", pc, 8'hFD);
    check("haltStayInstr", instr, 16'h803C);

    // Reset mid-fetch
    rstN = 1'b0;
    #3 rstN = 1'b1;
    tick();
    tick();
    check("refetchReq", imem.imemReq, 1'b1);
    #2 rstN = 1'b0;
    #1;
    check("asyncReqDrop", imem.imemReq, 1'b0);
    check("asyncPc", pc, 8'h00);
    check("asyncHalted", halted, 1'b0);
    imem.imemAck = 1'b1;
    imem.imemRdata = 16'hCAFE;
    tick();
    imem.imemAck = 1'b0;
    check("rstAckInstr", instr, 16'h0000);
    check("rstAckValid", instrValid, 1'b0);
    rstN = 1'b1;
    tick();
    check("postRstReq", imem.imemReq, 1'b1);
    check("postRstAddr", imem.imemAddr, 8'h00);
    check("postRstInstr", instr, 16'h0000);

    // Never ack: watchdog or indefinite wait
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) tick();
    check("toPendReq", imem.imemReq, 1'b1);
    check("toPendErr", fetchErr, 1'b0);
    tick();
    check("toErr", fetchErr, 1'b1);
    check("toHalted", halted, 1'b1);
    check("toReq", imem.imemReq, 1'b0);
`else
    for (int i = 0; i < 100; i++) tick();
    check("waitReq", imem.imemReq, 1'b1);
    check("waitErr", fetchErr, 1'b0);
    check("waitHalted", halted, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
